bmem_responder: RTL and testbench
=================================

// Module: bmem_responder
// PURPOSE
//  Synthesizable main-memory responder for the bmem_* burst interface driven by the line buffer.
//  Sits outside the chip top and answers its line reads and writes for simulation and FPGA bring-up.
//  Stores 256-bit lines as four 64-bit beats and queues outstanding reads.
//  Returns read data in request order after a fixed latency.
// PARAMETERS
//  LINE_IDX_BITS  10  line-index width; storage = 2**LINE_IDX_BITS lines x 32 B
//  READ_LATENCY   8   cycles from read accept to first rvalid beat (>=1)
//  QUEUE_DEPTH    4   max outstanding reads (power of 2, >=2)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset; synchronous, active-low
//  bmem_addr    in   32  request byte address; bits[4:0] ignored (line-aligned)
//  bmem_read    in   1   read request (one cycle per line)
//  bmem_write   in   1   write beat valid (four consecutive beats per line)
//  bmem_wdata   in   64  write beat data
//  bmem_ready   out  1   request/beat accepted this cycle when high
//  bmem_raddr   out  32  line address of the returning read; bits[4:0]=0
//  bmem_rdata   out  64  read beat data
//  bmem_rvalid  out  1   read beat valid
//  err          out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Reset (rst==0 at posedge): bmem_ready=0, rvalid=0, raddr=0, rdata=0, err=0, queue empty.
//   Write FSM goes to IDLE. Array contents are not cleared.
//   Reset mid-operation: pending reads dropped; already-written beats persist.
//  Index = bmem_addr[LINE_IDX_BITS+4:5]; higher bits ignored, so addresses alias.
//  Accept: a request/beat is accepted at a posedge with (read|write) && bmem_ready.
//  bmem_ready = rst && (wfsm!=IDLE || count<QUEUE_DEPTH); it is registered.
//  Write FSM states: IDLE -> B1 -> B2 -> B3 -> IDLE.
//   - Beat k (0..3) writes wdata into word k of the line, committed at that edge.
//   - IDLE->B1 on an accepted write. Each later beat advances on bmem_write=1.
//   - In B1..B3, bmem_write=0 sets err and returns to IDLE; the partial line is kept.
//   - bmem_addr is sampled on beat 0 only.
//  Read accept: snapshot the full 256-bit line from the array into the queue tail.
//   - Also store the aligned address and age=0 (sampled post-commit of prior edges).
//   - A read accepted the cycle after a write's beat 3 sees the new data.
//  Illegal requests set err and are ignored; no read is enqueued:
//   - read && write asserted together in IDLE: write wins.
//   - read asserted in B1..B3: the write beat still proceeds if bmem_write=1.
//  Age: each queue entry's age increments per cycle, saturating at READ_LATENCY.
//  Response FSM states: R_IDLE, R_BEAT (beat counter 0..3).
//   - R_IDLE->R_BEAT when the queue is non-empty and head age>=READ_LATENCY.
//   - In R_BEAT: rvalid=1, raddr=head addr, rdata=head word[beat].
//   - After beat 3: pop the head. Go straight to the next entry's beat 0 if eligible, else R_IDLE.
//  Latency: a read accepted at edge T drives beat 0 in cycle T+READ_LATENCY if the bus is free.
//   Beats are back-to-back, never gapped.
//  Full queue: ready=0 in IDLE. A pop and a push in the same cycle are both allowed.
//   Count is unchanged; ready recomputes next cycle.
//  Pointers wrap modulo QUEUE_DEPTH; count width is clog2(QUEUE_DEPTH)+1.
//  rvalid=0 and rdata/raddr hold their last values when not in R_BEAT.
// TESTING
//  1. Write line 0x100 with beats A0..A3 = 0x1111..,0x2222..,0x3333..,0x4444..; read 0x100 ->
//     4 rvalid beats in order, starting exactly 8 cycles after accept, raddr=0x100.
//  2. Issue 4 reads to 0x000,0x020,0x040,0x060 back-to-back ->
//     16 contiguous rvalid beats in order. A 5th read sees ready=0 until the first pop.
//  3. Read 0x200, then write 0x200 new data before the response ->
//     the returned data is the OLD line (snapshot); a following read returns the new data.
//  4. read=write=1 at 0x300 in IDLE -> write beat taken, err=1, no response ever appears.
//     Drop bmem_write after beat 1 -> err stays 1, FSM returns to IDLE.
//  5. Assert rst=0 with 2 reads queued and 1 beat emitted ->
//     rvalid=0 the next cycle, ready=0 during reset, and no stale beats after release.
//  6. Write 0x8000_0100 (LINE_IDX_BITS=10), then read 0x100 -> aliased data returned.

Source files
------------

// File: rtl/bmem_responder.sv
// Main-memory responder for the bmem_* burst bus: four-beat line writes, and reads that
// snapshot the line on accept and return it in request order after a fixed latency.
module bmem_responder #(
  parameter int LINE_IDX_BITS = 10,
  parameter int READ_LATENCY  = 8,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        err
);
  localparam int LINES = 2**LINE_IDX_BITS;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(READ_LATENCY + 1);

  // Encoding matters: the beat number equals the state value, and B3 + 1 wraps to IDLE.
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_B1 = 2'd1, W_B2 = 2'd2, W_B3 = 2'd3} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_BEAT = 1'b1} rstate_t;

  logic [63:0]              mem    [LINES][4];
  logic [63:0]              q_data [QUEUE_DEPTH][4];
  logic [31:0]              q_addr [QUEUE_DEPTH];
  logic [AGE_W-1:0]         age_q  [QUEUE_DEPTH];

  wstate_t                  wstate_q, wstate_d;
  rstate_t                  rstate_q, rstate_d;
  logic [1:0]               beat_q, beat_d;
  logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q, nxt_ptr, drv_ptr;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [LINE_IDX_BITS-1:0] addr_idx, widx_q, mem_idx;
  logic [1:0]               mem_word, drv_word;
  logic                     mem_we, push, pop, set_err, drive, head_elig, next_elig;
  logic                     unused_addr_bits;

  assign addr_idx         = bmem_addr[LINE_IDX_BITS+4:5];
  assign unused_addr_bits = ^bmem_addr[4:0];
  assign nxt_ptr          = rd_ptr_q + PTR_W'(1);
  // Eligibility is judged on the age the entry reaches at this edge, so beat 0 lands
  // exactly READ_LATENCY cycles after the accepting edge.
  assign head_elig = (count_q != '0) && (int'(age_q[rd_ptr_q]) >= READ_LATENCY - 1);
  assign next_elig = (count_q > CNT_W'(1)) && (int'(age_q[nxt_ptr]) >= READ_LATENCY - 1);

  always_comb begin
    wstate_d = wstate_q;
    mem_we   = 1'b0;
    mem_word = 2'd0;
    mem_idx  = widx_q;
    push     = 1'b0;
    set_err  = 1'b0;
    if (rst) begin
      unique case (wstate_q)
        W_IDLE: begin
          mem_idx = addr_idx;
          if (bmem_ready && bmem_write) begin
            mem_we   = 1'b1;
            set_err  = bmem_read;
            wstate_d = W_B1;
          end else if (bmem_ready && bmem_read) begin
            push = 1'b1;
          end
        end
        default: begin
          set_err = bmem_read;
          if (bmem_write) begin
            mem_we   = 1'b1;
            mem_word = wstate_q;
            wstate_d = wstate_t'(mem_word + 2'd1);
          end else begin
            set_err  = 1'b1;
            wstate_d = W_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    beat_d   = beat_q;
    pop      = 1'b0;
    drive    = 1'b0;
    drv_ptr  = rd_ptr_q;
    drv_word = 2'd0;
    unique case (rstate_q)
      R_IDLE: begin
        if (head_elig) begin
          rstate_d = R_BEAT;
          beat_d   = 2'd0;
          drive    = 1'b1;
        end
      end
      default: begin
        if (beat_q != 2'd3) begin
          beat_d   = beat_q + 2'd1;
          drive    = 1'b1;
          drv_word = beat_q + 2'd1;
        end else begin
          pop    = 1'b1;
          beat_d = 2'd0;
          if (next_elig) begin
            drive   = 1'b1;
            drv_ptr = nxt_ptr;
          end else begin
            rstate_d = R_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  // Control and output stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      wstate_q    <= W_IDLE;
      rstate_q    <= R_IDLE;
      beat_q      <= 2'd0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      bmem_ready  <= 1'b0;
      bmem_rvalid <= 1'b0;
      bmem_raddr  <= '0;
      bmem_rdata  <= '0;
      err         <= 1'b0;
    end else begin
      wstate_q    <= wstate_d;
      rstate_q    <= rstate_d;
      beat_q      <= beat_d;
      count_q     <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= nxt_ptr;
      bmem_ready  <= (wstate_d != W_IDLE) || (count_d < CNT_W'(QUEUE_DEPTH));
      bmem_rvalid <= drive;
      if (drive) begin
        bmem_raddr <= q_addr[drv_ptr];
        bmem_rdata <= q_data[drv_ptr][drv_word];
      end
      if (set_err)
        err <= 1'b1;
    end
  end

  // Storage stage: array, read snapshots and ages are never cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_idx][mem_word] <= bmem_wdata;
    if (mem_we && wstate_q == W_IDLE)
      widx_q <= addr_idx;
    if (push) begin
      q_addr[wr_ptr_q] <= {bmem_addr[31:5], 5'd0};
      for (int w = 0; w < 4; w++)
        q_data[wr_ptr_q][w] <= mem[addr_idx][w];
    end
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (push && wr_ptr_q == PTR_W'(i))
        age_q[i] <= '0;
      else if (age_q[i] != AGE_W'(READ_LATENCY))
        age_q[i] <= age_q[i] + AGE_W'(1);
    end
  end

endmodule

// File: tb/tb_bmem_responder.sv
// Scoreboard bench for bmem_responder: directed writes/reads push expected beats,
// a forked monitor pops and compares every rvalid beat (address, data, cycle).
module tb_bmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bmem_addr = '0;
  logic        bmem_read = 1'b0;
  logic        bmem_write = 1'b0;
  logic [63:0] bmem_wdata = '0;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        err;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   beats_seen = 0;
  int   cyc = 0;

  bmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bmem_rvalid === 1'b1) begin
        beats_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: raddr=%h rdata=%h cyc=%0d", bmem_raddr, bmem_rdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bmem_raddr !== e.addr || bmem_rdata !== e.data || (e.due >= 0 && cyc != e.due)) begin
            failures++;
            $display("FAIL rbeat: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                     bmem_raddr, bmem_rdata, cyc, e.addr, e.data, e.due);
          end
        end
      end
    end
  endtask

  task automatic expect_line(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3, input int due0);
    logic [63:0] d [4];
    exp_t e;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      e.addr = a;
      e.data = d[k];
      e.due  = (due0 < 0) ? -1 : due0 + k;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (bmem_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bmem_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s: ready still %b after %0d cycles, expected 1", name, bmem_ready, n);
    end
  endtask

  task automatic write_line(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
    logic [63:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    bmem_addr = a;
    for (int k = 0; k < 4; k++) begin
      bmem_write = 1'b1;
      bmem_wdata = d[k];
      wait_ready("write_ready");
      @(posedge clk); #1;
    end
    bmem_write = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output int acc);
    bmem_addr = a;
    bmem_read = 1'b1;
    wait_ready("read_ready");
    @(posedge clk); #1;
    acc = cyc;
    bmem_read = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_int(name, exp_q.size(), 0);
  endtask

  function automatic logic [63:0] pat(input int n, input int k);
    return {32'hC0DE_0000 + 32'(n), 32'h0000_00B0 + 32'(k)};
  endfunction

  localparam logic [63:0] A0 = 64'h1111_1111_1111_1111, A1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] A2 = 64'h3333_3333_3333_3333, A3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] O0 = 64'h0AD0_0000_0000_0000, O1 = 64'h0AD1_0000_0000_0001;
  localparam logic [63:0] O2 = 64'h0AD2_0000_0000_0002, O3 = 64'h0AD3_0000_0000_0003;
  localparam logic [63:0] N0 = 64'hBEE0_5555_0000_0010, N1 = 64'hBEE1_5555_0000_0011;
  localparam logic [63:0] N2 = 64'hBEE2_5555_0000_0012, N3 = 64'hBEE3_5555_0000_0013;
  localparam logic [63:0] P0 = 64'h7000_0000_0000_0000, P1 = 64'h7000_0000_0000_0001;
  localparam logic [63:0] P2 = 64'h7000_0000_0000_0002, P3 = 64'h7000_0000_0000_0003;
  localparam logic [63:0] D0 = 64'hDDDD_0000_0000_0000, D1 = 64'hDDDD_0000_0000_0001;
  localparam logic [63:0] E0 = 64'hE0E0_E0E0_0000_0000, E1 = 64'hE1E1_E1E1_0000_0001;
  localparam logic [63:0] E2 = 64'hE2E2_E2E2_0000_0002, E3 = 64'hE3E3_E3E3_0000_0003;

  initial begin
    int t, t0, t1, t2, t3, t4, base, n;
    fork
      run_monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_ready", bmem_ready, 1'b0);
    check_bit("rst_rvalid", bmem_rvalid, 1'b0);
    check_word("rst_raddr", 64'(bmem_raddr), 64'd0);
    check_word("rst_rdata", bmem_rdata, 64'd0);
    check_bit("rst_err", err, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_bit("ready_after_release", bmem_ready, 1'b1);

    // 1: basic write then read, latency 8
    write_line(32'h0000_0100, A0, A1, A2, A3);
    do_read(32'h0000_0100, t);
    expect_line(32'h0000_0100, A0, A1, A2, A3, t + 8);
    drain("drain_t1");

    // 2: four back-to-back reads fill the queue; fifth waits for the first pop
    for (int ln = 0; ln < 4; ln++)
      write_line(32'(ln * 32), pat(ln, 0), pat(ln, 1), pat(ln, 2), pat(ln, 3));
    do_read(32'h000, t0);
    expect_line(32'h000, pat(0, 0), pat(0, 1), pat(0, 2), pat(0, 3), t0 + 8);
    do_read(32'h020, t1);
    expect_line(32'h020, pat(1, 0), pat(1, 1), pat(1, 2), pat(1, 3), t0 + 12);
    do_read(32'h040, t2);
    expect_line(32'h040, pat(2, 0), pat(2, 1), pat(2, 2), pat(2, 3), t0 + 16);
    do_read(32'h060, t3);
    expect_line(32'h060, pat(3, 0), pat(3, 1), pat(3, 2), pat(3, 3), t0 + 20);
    check_int("b2b_accept", t3 - t0, 3);
    check_bit("full_ready", bmem_ready, 1'b0);
    do_read(32'h000, t4);
    check_int("fifth_accept", t4 - t0, 13);
    expect_line(32'h000, pat(0, 0), pat(0, 1), pat(0, 2), pat(0, 3), t0 + 24);
    drain("drain_t2");

    // 3: read snapshot is taken at accept, later write does not leak in
    write_line(32'h200, O0, O1, O2, O3);
    do_read(32'h200, t);
    expect_line(32'h200, O0, O1, O2, O3, t + 8);
    write_line(32'h200, N0, N1, N2, N3);
    do_read(32'h200, t1);
    check_int("snap_second_accept", t1 - t, 5);
    expect_line(32'h200, N0, N1, N2, N3, t + 13);
    drain("drain_t3");
    check_bit("no_err_legal", err, 1'b0);

    // 4: read+write together, then aborted burst; partial line kept
    write_line(32'h300, P0, P1, P2, P3);
    bmem_addr  = 32'h300;
    bmem_read  = 1'b1;
    bmem_write = 1'b1;
    bmem_wdata = D0;
    wait_ready("rw_ready");
    @(posedge clk); #1;
    bmem_read = 1'b0;
    check_bit("rw_err", err, 1'b1);
    bmem_wdata = D1;
    @(posedge clk); #1;
    bmem_write = 1'b0;
    @(posedge clk); #1;
    check_bit("abort_err", err, 1'b1);
    check_bit("abort_ready", bmem_ready, 1'b1);
    base = beats_seen;
    repeat (20) @(posedge clk);
    #1;
    check_int("no_rw_response", beats_seen, base);
    do_read(32'h300, t);
    expect_line(32'h300, D0, D1, P2, P3, t + 8);
    drain("drain_t4");
    check_bit("err_sticky", err, 1'b1);

    // 5: reset with two reads queued and one beat emitted
    do_read(32'h100, t);
    expect_line(32'h100, A0, A1, A2, A3, t + 8);
    do_read(32'h200, t1);
    expect_line(32'h200, N0, N1, N2, N3, -1);
    n = 0;
    while (bmem_rvalid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_bit("rst_first_beat_seen", bmem_rvalid, 1'b1);
    rst = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(posedge clk); #1;
    check_bit("midrst_rvalid", bmem_rvalid, 1'b0);
    check_bit("midrst_ready", bmem_ready, 1'b0);
    check_bit("midrst_err", err, 1'b0);
    check_word("midrst_raddr", 64'(bmem_raddr), 64'd0);
    check_word("midrst_rdata", bmem_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    base = beats_seen;
    repeat (30) @(posedge clk);
    #1;
    check_int("no_stale_beats", beats_seen, base);
    check_int("no_stale_expect", exp_q.size(), 0);

    // 6: high address bits alias onto the same line
    write_line(32'h8000_0100, E0, E1, E2, E3);
    do_read(32'h0000_0100, t);
    expect_line(32'h0000_0100, E0, E1, E2, E3, t + 8);
    drain("drain_t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
